// File: rtl/udp_tx_sched_pkg.sv
// Shared types and widths for the UDP transmit scheduler.
package udp_tx_sched_pkg;

    localparam int PKT_LEN_W = 16;
    localparam int FRAME_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT_DATA,
        SEND,
        WAIT_DONE,
        GAP,
        DONE
    } sched_state_e;

endpackage

// File: rtl/sched_cycle_timer.sv
// Loadable down-counter with a zero flag. The scheduler shares one instance
// between the inter-packet gap and the watchdog.
module sched_cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // A load wins over counting; once at zero the count holds there.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/udp_tx_scheduler.sv
// Splits one acquisition frame into UDP transmit requests of at most MAX_PAYLOAD bytes.
// Define TX_SCHED_TIMEOUT_EN to enable the WAIT_DATA/WAIT_DONE watchdog and the err flag.
module udp_tx_scheduler
    import udp_tx_sched_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = 1024,
    parameter int unsigned IPG_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1250000,
    parameter int unsigned CNT_W          = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 restart_req_i,
    input  logic [FRAME_W-1:0]   frame_bytes_i,
    input  logic [CNT_W-1:0]     fifo_rd_count_i,
    input  logic                 fifo_empty_i,
    input  logic                 tx_done_i,
    output logic                 tx_en_pulse_o,
    output logic [PKT_LEN_W-1:0] pkt_len_o,
    output logic [PKT_LEN_W-1:0] pkt_seq_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 err_o
);

    localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > IPG_CYCLES) ? TIMEOUT_CYCLES : IPG_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    sched_state_e         state_q;
    logic                 restart_prev_q;
    logic [FRAME_W-1:0]   remaining_q;
    logic [PKT_LEN_W-1:0] pkt_len_q;
    logic [PKT_LEN_W-1:0] pkt_seq_q;
    logic                 tx_en_pulse_q;
    logic                 busy_q;
    logic                 frame_done_q;
    logic                 zero_frame_q;

    logic                 start_edge;
    logic                 data_ready;
    logic [FRAME_W-1:0]   rem_after_pkt;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_zero;

    assign start_edge    = restart_req_i && !restart_prev_q;
    assign data_ready    = !fifo_empty_i && (PKT_LEN_W'(fifo_rd_count_i) >= pkt_len_q);
    assign rem_after_pkt = remaining_q - FRAME_W'(pkt_len_q);

    // The timer is reloaded on the edge that enters GAP, or (with the watchdog)
    // on the edges that enter WAIT_DATA and WAIT_DONE.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = TIMER_W'(IPG_CYCLES - 1);
        if (state_q == WAIT_DONE && tx_done_i) begin
            timer_load = 1'b1;
        end
`ifdef TX_SCHED_TIMEOUT_EN
        if (state_q == CALC || state_q == SEND) begin
            timer_load = 1'b1;
            timer_val  = TIMER_W'(TIMEOUT_CYCLES - 1);
        end
`endif
    end

    sched_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

`ifdef TX_SCHED_TIMEOUT_EN
    logic err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            restart_prev_q <= 1'b0;
            remaining_q    <= '0;
            pkt_len_q      <= '0;
            pkt_seq_q      <= '0;
            tx_en_pulse_q  <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            zero_frame_q   <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
        end else begin
            restart_prev_q <= restart_req_i;
            tx_en_pulse_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        busy_q    <= 1'b1;
                        pkt_seq_q <= '0;
`ifdef TX_SCHED_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        if (frame_bytes_i == '0) begin
                            zero_frame_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            remaining_q <= frame_bytes_i;
                            state_q     <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (remaining_q < FRAME_W'(MAX_PAYLOAD)) begin
                        pkt_len_q <= remaining_q[PKT_LEN_W-1:0];
                    end else begin
                        pkt_len_q <= PKT_LEN_W'(MAX_PAYLOAD);
                    end
                    state_q <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (data_ready) begin
                        tx_en_pulse_q <= 1'b1;
                        state_q       <= SEND;
                    end
`ifdef TX_SCHED_TIMEOUT_EN
                    else if (timer_zero) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`endif
                end
                SEND: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done_i) begin
                        remaining_q <= rem_after_pkt;
                        if (rem_after_pkt == '0) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            pkt_seq_q <= pkt_seq_q + PKT_LEN_W'(1);
                            state_q   <= GAP;
                        end
                    end
`ifdef TX_SCHED_TIMEOUT_EN
                    else if (timer_zero) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`endif
                end
                GAP: begin
                    if (timer_zero) begin
                        state_q <= CALC;
                    end
                end
                DONE: begin
                    // An empty frame dwells here one extra cycle so its pulse lands two cycles after the edge.
                    if (zero_frame_q) begin
                        zero_frame_q <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_en_pulse_o = tx_en_pulse_q;
    assign pkt_len_o     = pkt_len_q;
    assign pkt_seq_o     = pkt_seq_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler; the watchdog scenario runs only when
// TX_SCHED_TIMEOUT_EN is defined.
module tb_udp_tx_scheduler;

    localparam int MAX_PAY    = 1024;
    localparam int IPG        = 8;
    localparam int TIMEOUT    = 100;
    localparam int TX_LATENCY = 5;

    typedef struct {
        int len;
        int seq;
        int at;
    } pktExp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        restartReq;
    logic [31:0] frameBytes;
    logic [14:0] fifoCount;
    logic        fifoEmpty;
    logic        txDone = 1'b0;
    logic        txEnPulse;
    logic [15:0] pktLen;
    logic [15:0] pktSeq;
    logic        busy;
    logic        frameDone;
    logic        err;

    int      cycleCnt = 0;
    int      lastDoneCycle = -1000;
    int      doneTimer = 0;
    bit      autoDone = 1'b1;
    int      checkCount = 0;
    int      errorCount = 0;
    pktExp_t pktQ[$];
    int      doneQ[$];
    pktExp_t expPkt;
    int      expDone;

    udp_tx_scheduler #(
        .MAX_PAYLOAD    (MAX_PAY),
        .IPG_CYCLES     (IPG),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (15)
    ) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .restart_req_i   (restartReq),
        .frame_bytes_i   (frameBytes),
        .fifo_rd_count_i (fifoCount),
        .fifo_empty_i    (fifoEmpty),
        .tx_done_i       (txDone),
        .tx_en_pulse_o   (txEnPulse),
        .pkt_len_o       (pktLen),
        .pkt_seq_o       (pktSeq),
        .busy_o          (busy),
        .frame_done_o    (frameDone),
        .err_o           (err)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] bytes, output int startCycle);
        @(negedge clk);
        frameBytes = bytes;
        restartReq = 1'b1;
        startCycle = cycleCnt;
        @(negedge clk);
        restartReq = 1'b0;
    endtask

    task automatic pushPkt(input int len, input int seq, input int at);
        pktExp_t p;
        p.len = len;
        p.seq = seq;
        p.at  = at;
        pktQ.push_back(p);
    endtask

    task automatic waitUntil(input int c);
        while (cycleCnt < c) @(negedge clk);
    endtask

    task automatic waitIdle(input string name, output int idleCycle);
        int k = 0;
        idleCycle = -1;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (busy) checkOutput(name, 1, 0);
        else idleCycle = cycleCnt;
    endtask

    // Transmitter model: answers each tx_en_pulse with tx_done TX_LATENCY cycles later.
    always @(negedge clk) begin
        txDone = 1'b0;
        if (!autoDone) begin
            doneTimer = 0;
        end else if (doneTimer > 0) begin
            doneTimer--;
            if (doneTimer == 0) begin
                txDone = 1'b1;
                lastDoneCycle = cycleCnt;
            end
        end
        if (txEnPulse === 1'b1 && autoDone) doneTimer = TX_LATENCY;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    // at >= 0 is an exact cycle; -1 means relative to the last tx_done.
    always @(negedge clk) begin
        if (txEnPulse === 1'b1) begin
            if (pktQ.size() == 0) begin
                checkOutput("unexpected tx_en_pulse", 1, 0);
            end else begin
                expPkt = pktQ.pop_front();
                checkOutput("pkt_len", int'(pktLen), expPkt.len);
                checkOutput("pkt_seq", int'(pktSeq), expPkt.seq);
                if (expPkt.at >= 0) checkOutput("tx_en cycle", cycleCnt, expPkt.at);
                else checkOutput("tx_en after gap", cycleCnt, lastDoneCycle + IPG + 3);
            end
        end
        if (frameDone === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected frame_done", 1, 0);
            end else begin
                expDone = doneQ.pop_front();
                if (expDone >= 0) checkOutput("frame_done cycle", cycleCnt, expDone);
                else checkOutput("frame_done after tx_done", cycleCnt, lastDoneCycle + 1);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL global timeout: cycle %0d required < 20000", cycleCnt);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        int t;
        rst        = 1'b1;
        restartReq = 1'b0;
        frameBytes = '0;
        fifoCount  = '0;
        fifoEmpty  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset tx_en_pulse", int'(txEnPulse), 0);
        checkOutput("reset pkt_len", int'(pktLen), 0);
        checkOutput("reset pkt_seq", int'(pktSeq), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset frame_done", int'(frameDone), 0);
        checkOutput("reset err", int'(err), 0);
        rst       = 1'b0;
        fifoCount = 15'd600;
        fifoEmpty = 1'b0;
        @(negedge clk);

        $display("[TB] single packet");
        applyStimulus(32'd512, n);
        pushPkt(512, 0, n + 3);
        doneQ.push_back(-1);
        waitIdle("single idle timeout", t);
        checkOutput("single busy low cycle", t, lastDoneCycle + 2);

        $display("[TB] multi packet");
        fifoCount = 15'd2000;
        applyStimulus(32'd2500, n);
        pushPkt(1024, 0, n + 3);
        pushPkt(1024, 1, -1);
        pushPkt(452, 2, -1);
        doneQ.push_back(-1);
        waitIdle("multi idle timeout", t);
        checkOutput("multi busy low cycle", t, lastDoneCycle + 2);

        $display("[TB] data starvation");
        fifoCount = 15'd100;
        applyStimulus(32'd1024, n);
        waitUntil(n + 10);
        checkOutput("starved busy", int'(busy), 1);
        pushPkt(1024, 0, cycleCnt + 1);
        doneQ.push_back(-1);
        fifoCount = 15'd1024;
        waitIdle("starve idle timeout", t);
        checkOutput("starve busy low cycle", t, lastDoneCycle + 2);
        fifoCount = 15'd2000;

        $display("[TB] zero length frame");
        applyStimulus(32'd0, n);
        doneQ.push_back(n + 2);
        waitIdle("zero idle timeout", t);
        checkOutput("zero busy low cycle", t, n + 3);

        $display("[TB] ignored restart edge");
        applyStimulus(32'd2048, n);
        pushPkt(1024, 0, n + 3);
        pushPkt(1024, 1, -1);
        doneQ.push_back(-1);
        waitUntil(n + 10);
        restartReq = 1'b1;
        waitUntil(n + 14);
        restartReq = 1'b0;
        waitIdle("ignore idle timeout", t);
        checkOutput("ignore busy low cycle", t, lastDoneCycle + 2);
        repeat (10) @(negedge clk);
        checkOutput("edge not queued", int'(busy), 0);

        $display("[TB] reset mid-frame");
        autoDone = 1'b0;
        applyStimulus(32'd512, n);
        pushPkt(512, 0, n + 3);
        waitUntil(n + 6);
        checkOutput("in-flight busy", int'(busy), 1);
        checkOutput("in-flight pkt_len", int'(pktLen), 512);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset tx_en_pulse", int'(txEnPulse), 0);
        checkOutput("midreset pkt_len", int'(pktLen), 0);
        checkOutput("midreset pkt_seq", int'(pktSeq), 0);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset frame_done", int'(frameDone), 0);
        checkOutput("midreset err", int'(err), 0);
        rst      = 1'b0;
        autoDone = 1'b1;
        @(negedge clk);
        applyStimulus(32'd300, n);
        pushPkt(300, 0, n + 3);
        doneQ.push_back(-1);
        waitIdle("post-reset idle timeout", t);
        checkOutput("post-reset busy low cycle", t, lastDoneCycle + 2);

`ifdef TX_SCHED_TIMEOUT_EN
        $display("[TB] watchdog");
        autoDone = 1'b0;
        applyStimulus(32'd256, n);
        pushPkt(256, 0, n + 3);
        waitUntil(n + 103);
        checkOutput("watchdog err before limit", int'(err), 0);
        checkOutput("watchdog busy before limit", int'(busy), 1);
        @(negedge clk);
        checkOutput("watchdog err at limit", int'(err), 1);
        checkOutput("watchdog busy at limit", int'(busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("watchdog err sticky", int'(err), 1);
        autoDone = 1'b1;
        applyStimulus(32'd128, n);
        checkOutput("err cleared by start", int'(err), 0);
        pushPkt(128, 0, n + 3);
        doneQ.push_back(-1);
        waitIdle("watchdog recover timeout", t);
        checkOutput("recover busy low cycle", t, lastDoneCycle + 2);
`else
        checkOutput("err tied low", int'(err), 0);
`endif

        repeat (5) @(negedge clk);
        checkOutput("pkt scoreboard drained", pktQ.size(), 0);
        checkOutput("frame_done scoreboard drained", doneQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Packetizes one acquisition frame into a sequence of UDP transmit requests in the 125 MHz transmit clock domain. It sits between the ADC transmit FIFO (read side) and the UDP/GMII transmitter. On each restart request it splits the requested frame byte count into packets of at most `MAX_PAYLOAD` bytes, waits until each packet's data is present in the FIFO, fires the transmitter, and enforces an inter-packet gap.

## Interface
Parameters:
- `MAX_PAYLOAD`, 1024: maximum UDP payload bytes per packet; even; range 2..1472.
- `IPG_CYCLES`, 64: idle cycles between `tx_done` and the next packet's length calculation; ≥1.
- `TIMEOUT_CYCLES`, 1250000: watchdog limit in cycles (10 ms). Used only with the timeout macro.
- `CNT_W`, 15: width of the FIFO read-count input.

Ports:
- `clk` in 1: 125 MHz transmit clock.
- `reset` in 1: synchronous, active-high.
- `restart_req` in 1: level from the command path, already synchronized into `clk`; the rising edge starts a frame.
- `frame_bytes` in 32: total frame bytes, already synchronized; sampled on the start edge.
- `fifo_rd_count` in `CNT_W`: FIFO bytes available to read.
- `fifo_empty` in 1: FIFO read-side empty.
- `tx_done` in 1: one-cycle pulse from the transmitter when a packet is complete.
- `tx_en_pulse` out 1: one-cycle transmit start.
- `pkt_len` out 16: payload length; held stable from `tx_en_pulse` until `tx_done`.
- `pkt_seq` out 16: index of the current packet within the frame; 0 for the first packet.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse when the frame completes.
- `err` out 1: sticky watchdog abort flag; cleared by reset or by the next start edge.

## Operation
- Start edge detection: `restart_req` high this cycle and low in a register the previous cycle. Edges that occur while `busy` is high are ignored; they are not queued.
- FSM states: IDLE, CALC, WAIT_DATA, SEND, WAIT_DONE, GAP, DONE.
- IDLE, on a start edge:
  - `frame_bytes`==0 → DONE.
  - Otherwise → CALC, with `remaining` ← `frame_bytes`, `pkt_seq` ← 0, `err` ← 0.
- CALC: `pkt_len` ← min(`remaining`, `MAX_PAYLOAD`). The compare is 32-bit and the result is truncated to 16 bits, which is safe because `MAX_PAYLOAD` ≤ 1472. → WAIT_DATA.
- WAIT_DATA: → SEND when `!fifo_empty` and `fifo_rd_count` ≥ `pkt_len`. `fifo_rd_count` is zero-extended to 16 bits for the compare.
- SEND: `tx_en_pulse`=1 for exactly this cycle. → WAIT_DONE.
- WAIT_DONE, on `tx_done`: `remaining` ← `remaining` − `pkt_len`.
  - If the new `remaining` is 0 → DONE.
  - Otherwise → GAP, and `pkt_seq` increments, wrapping modulo 2^16.
- GAP: counts `IPG_CYCLES` cycles, then → CALC.
- DONE: `frame_done`=1 for this cycle. → IDLE.
- `tx_done` in any state other than WAIT_DONE is ignored.
- A final packet with an odd length is allowed. The block does no padding; the transmitter handles minimum frame size.
- `reset` in any state: FSM → IDLE and all outputs return to their reset values within one cycle. A packet already in flight is abandoned; the transmitter recovers on its own reset.

## Timing
- Reset values: `tx_en_pulse`=0, `pkt_len`=0, `pkt_seq`=0, `busy`=0, `frame_done`=0, `err`=0.
- All outputs are registered.
- If the start edge is sampled at cycle N and data is already present:
  - CALC at N+1.
  - WAIT_DATA at N+2.
  - `tx_en_pulse` high at N+3.
- If `tx_done` is sampled at cycle M (non-last packet): next `tx_en_pulse` no earlier than M+`IPG_CYCLES`+3.
- If `tx_done` is sampled at cycle M (last packet): `frame_done` at M+1, `busy` low at M+2.
- `frame_bytes`==0: `frame_done` at N+2 and no `tx_en_pulse`.

## Configuration
- `TX_SCHED_TIMEOUT_EN` defined:
  - A watchdog counter runs in WAIT_DATA and WAIT_DONE and is cleared on each entry to those states.
  - Reaching `TIMEOUT_CYCLES` sets `err`=1 and sends the FSM directly to IDLE, with no `frame_done`.
- `TX_SCHED_TIMEOUT_EN` undefined:
  - No watchdog; WAIT_DATA and WAIT_DONE wait indefinitely.
  - `err` is tied to 0.

## Structure
- Package `udp_tx_sched_pkg`: FSM state enum, `PKT_LEN_W`=16, `FRAME_W`=32.
- One sub-module, `sched_cycle_timer`: loadable down-counter with a zero flag. It is shared between the GAP count and the watchdog, since the two are never active together.

## Test plan
- Single packet: `frame_bytes`=512, `fifo_rd_count`=600 → one `tx_en_pulse` at N+3 with `pkt_len`=512 and `pkt_seq`=0; `tx_done` → `frame_done`; `busy` low 2 cycles later.
- Multi-packet: `frame_bytes`=2500, `MAX_PAYLOAD`=1024 → `pkt_len` sequence 1024, 1024, 452; `pkt_seq` 0, 1, 2; gaps ≥ `IPG_CYCLES`; one `frame_done`.
- Data starvation: `fifo_rd_count`=100 with `pkt_len`=1024 → no pulse; raising the count to 1024 → pulse within 1 cycle after WAIT_DATA samples it.
- Zero length and ignored edges: `frame_bytes`=0 → `frame_done` at N+2 with no `tx_en_pulse`; a second restart edge mid-frame → no effect on the sequence.
- Watchdog (with the macro, `TIMEOUT_CYCLES`=100): `tx_done` withheld → `err`=1 at 100 cycles, FSM returns to IDLE, no `frame_done`; the next start edge clears `err`.
- Reset mid-frame: assert `reset` in WAIT_DONE → all outputs at reset values the next cycle; a new frame proceeds normally.
